// File: rtl/zex_signal_drive.sv
// rtl/zex_signal_drive.sv - registered external trigger/gate pin driver with programmable delay, width and gap
// Optional one-deep pending request slot: define ZEX_SIG_DRIVE_PENDING_EN.
module zex_signal_drive #(
    parameter int   DLY_W      = 16,
    parameter int   WID_W      = 16,
    parameter int   GAP_CYCLES = 4,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trig_in,
    input  logic [DLY_W-1:0] dly_cfg,
    input  logic [WID_W-1:0] wid_cfg,
    output logic             trig_ack,
    output logic             busy,
    output logic             done,
    output logic             overrun,
    output logic             sig_out
);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int DW_W  = (DLY_W > WID_W) ? DLY_W : WID_W;
    localparam int CNT_W = (DW_W > GAP_W) ? DW_W : GAP_W;
    localparam logic [CNT_W-1:0] GAP_LD = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;

    typedef enum logic [1:0] {S_IDLE, S_DELAY, S_ACTIVE, S_GAP} state_t;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [DLY_W-1:0] r_dly;
    logic [WID_W-1:0] r_wid;
    logic             r_req, r_ack_p, r_ovr_p;
    logic             w_end, w_open, w_accept, w_drop, w_store, w_pnd_v, w_consume;
    logic             w_start, w_done_nxt;
    logic [DLY_W-1:0] w_src_dly;
    logic [WID_W-1:0] w_src_wid;
    logic [WID_W-1:0] w_wid_m1;

    // Widths are held as (width-1) so the all-ones width still fits the counter.
    assign w_wid_m1 = (wid_cfg == '0) ? '0 : wid_cfg - 1'b1;
    assign w_end    = (r_cnt == '0) &&
                      ((r_state == S_GAP) || ((r_state == S_ACTIVE) && (GAP_CYCLES == 0)));

`ifdef ZEX_SIG_DRIVE_PENDING_EN
    logic             r_pnd_v;
    logic [DLY_W-1:0] r_pnd_dly;
    logic [WID_W-1:0] r_pnd_wid;

    assign w_pnd_v   = r_pnd_v;
    assign w_consume = w_end && r_pnd_v;
    assign w_store   = trig_in && !w_open && (!r_pnd_v || w_consume);
    assign w_src_dly = (r_state == S_IDLE) ? r_dly : r_pnd_dly;
    assign w_src_wid = (r_state == S_IDLE) ? r_wid : r_pnd_wid;
`else
    assign w_pnd_v   = 1'b0;
    assign w_consume = 1'b0;
    assign w_store   = 1'b0;
    assign w_src_dly = r_dly;
    assign w_src_wid = r_wid;
`endif

    // A request is taken normally when idle or on the very edge the FSM returns to idle.
    assign w_open   = ((r_state == S_IDLE) && !r_req) || (w_end && !w_pnd_v);
    assign w_accept = trig_in && w_open;
    assign w_drop   = trig_in && !w_open && !w_store;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_start     = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE:   w_start = r_req;
            S_DELAY: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_ACTIVE;
                    w_cnt_nxt   = CNT_W'(r_wid);
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            S_ACTIVE: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else if (GAP_CYCLES > 0) begin
                    w_state_nxt = S_GAP;
                    w_cnt_nxt   = GAP_LD;
                end
            end
            S_GAP: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_end) begin
            if (w_pnd_v) begin
                w_start = 1'b1;
            end else begin
                w_state_nxt = S_IDLE;
                w_done_nxt  = 1'b1;
            end
        end
        if (w_start) begin
            if (w_src_dly != '0) begin
                w_state_nxt = S_DELAY;
                w_cnt_nxt   = CNT_W'(w_src_dly - 1'b1);
            end else begin
                w_state_nxt = S_ACTIVE;
                w_cnt_nxt   = CNT_W'(w_src_wid);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_dly     <= '0;
            r_wid     <= '0;
            r_req     <= 1'b0;
            r_ack_p   <= 1'b0;
            r_ovr_p   <= 1'b0;
            trig_ack  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            overrun   <= 1'b0;
            sig_out   <= IDLE_LEVEL;
`ifdef ZEX_SIG_DRIVE_PENDING_EN
            r_pnd_v   <= 1'b0;
            r_pnd_dly <= '0;
            r_pnd_wid <= '0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_req    <= w_accept;
            r_ack_p  <= w_accept || w_store;
            r_ovr_p  <= w_drop;
            trig_ack <= r_ack_p;
            overrun  <= r_ovr_p;
            busy     <= (w_state_nxt != S_IDLE);
            done     <= w_done_nxt;
            sig_out  <= (w_state_nxt == S_ACTIVE) ? ~IDLE_LEVEL : IDLE_LEVEL;
            if (w_accept) begin
                r_dly <= dly_cfg;
                r_wid <= w_wid_m1;
            end else if (w_consume) begin
                r_wid <= w_src_wid;
            end
`ifdef ZEX_SIG_DRIVE_PENDING_EN
            if (w_store) begin
                r_pnd_v   <= 1'b1;
                r_pnd_dly <= dly_cfg;
                r_pnd_wid <= w_wid_m1;
            end else if (w_consume) begin
                r_pnd_v <= 1'b0;
            end
`endif
        end
    end
endmodule

// File: tb/tb_zex_signal_drive.sv
// tb/tb_zex_signal_drive.sv - directed self-checking bench for zex_signal_drive
module tb_zex_signal_drive;
    logic        clk = 1'b0;
    logic        rst;
    logic        trig0, trig1;
    logic [15:0] dly0, wid0, dly1, wid1;
    logic        ack0, busy0, done0, ovr0, sig0;
    logic        ack1, busy1, done1, ovr1, sig1;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          n;
    int          pulses;
    logic        prev_sig;

    zex_signal_drive #(.DLY_W(16), .WID_W(16), .GAP_CYCLES(4), .IDLE_LEVEL(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .trig_in(trig0), .dly_cfg(dly0), .wid_cfg(wid0),
        .trig_ack(ack0), .busy(busy0), .done(done0), .overrun(ovr0), .sig_out(sig0)
    );

    zex_signal_drive #(.DLY_W(16), .WID_W(16), .GAP_CYCLES(0), .IDLE_LEVEL(1'b0)) u_dut1 (
        .clk(clk), .rst(rst), .trig_in(trig1), .dly_cfg(dly1), .wid_cfg(wid1),
        .trig_ack(ack1), .busy(busy1), .done(done1), .overrun(ovr1), .sig_out(sig1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_edge(input string t, input int d, input int e, input logic eack,
                            input logic ebusy, input logic esig, input logic edone, input logic eovr);
        logic a, b, s, dn, o;
        a  = (d == 0) ? ack0  : ack1;
        b  = (d == 0) ? busy0 : busy1;
        s  = (d == 0) ? sig0  : sig1;
        dn = (d == 0) ? done0 : done1;
        o  = (d == 0) ? ovr0  : ovr1;
        chk($sformatf("%s e%0d ack", t, e),  {31'b0, a},  {31'b0, eack});
        chk($sformatf("%s e%0d busy", t, e), {31'b0, b},  {31'b0, ebusy});
        chk($sformatf("%s e%0d sig", t, e),  {31'b0, s},  {31'b0, esig});
        chk($sformatf("%s e%0d done", t, e), {31'b0, dn}, {31'b0, edone});
        chk($sformatf("%s e%0d ovr", t, e),  {31'b0, o},  {31'b0, eovr});
    endtask

    initial begin
        rst = 1'b1;
        trig0 = 1'b0; dly0 = '0; wid0 = '0;
        trig1 = 1'b0; dly1 = '0; wid1 = '0;
        step();
        step();
        chk_edge("reset", 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_edge("reset1", 1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        step();

        // T2: dly=3 wid=5 gap=4, request sampled at relative edge 0
        trig0 = 1'b1; dly0 = 16'd3; wid0 = 16'd5;
        step();
        trig0 = 1'b0; dly0 = 16'd7; wid0 = 16'd9;
        for (int e = 1; e <= 14; e++) begin
            step();
            chk_edge("T2", 0, e, e == 1, (e >= 1) && (e <= 12), (e >= 4) && (e <= 8), e == 13, 1'b0);
        end

        // T3a: dly=0 wid=0 -> single active cycle right after acceptance
        trig0 = 1'b1; dly0 = 16'd0; wid0 = 16'd0;
        step();
        trig0 = 1'b0;
        for (int e = 1; e <= 6; e++) begin
            step();
            chk_edge("T3a", 0, e, e == 1, e <= 5, e == 1, e == 6, 1'b0);
        end

        // T3b: maximum delay
        trig0 = 1'b1; dly0 = 16'hFFFF; wid0 = 16'd1;
        step();
        trig0 = 1'b0;
        n = 0;
        while (sig0 == 1'b0 && n < 70000) begin
            step();
            n++;
        end
        chk("T3b first active edge", n, 65536);
        step();
        chk("T3b width one", {31'b0, sig0}, 32'd0);
        for (int i = 0; i < 4; i++) step();
        chk("T3b done", {31'b0, done0}, 32'd1);
        chk("T3b busy", {31'b0, busy0}, 32'd0);

`ifdef ZEX_SIG_DRIVE_PENDING_EN
        // T5: A(dly1,wid2), B during A ACTIVE (edge 3), C during GAP (edge 5)
        trig0 = 1'b1; dly0 = 16'd1; wid0 = 16'd2;
        step();
        for (int e = 1; e <= 18; e++) begin
            trig0 = (e == 3) || (e == 5);
            dly0  = (e == 3) ? 16'd2 : 16'd5;
            wid0  = (e == 3) ? 16'd3 : 16'd5;
            step();
            chk_edge("T5", 0, e, (e == 1) || (e == 4), e <= 16,
                     (e == 2) || (e == 3) || (e >= 10 && e <= 12), e == 17, e == 6);
        end
        trig0 = 1'b0;
`else
        // T4: second request during DELAY is dropped
        trig0 = 1'b1; dly0 = 16'd3; wid0 = 16'd2;
        step();
        pulses = 0;
        prev_sig = sig0;
        for (int e = 1; e <= 12; e++) begin
            trig0 = (e == 2);
            dly0  = 16'd0;
            wid0  = 16'd7;
            step();
            chk_edge("T4", 0, e, e == 1, e <= 9, (e == 4) || (e == 5), e == 10, e == 3);
            if (sig0 && !prev_sig) pulses++;
            prev_sig = sig0;
        end
        chk("T4 pulse count", pulses, 1);
        trig0 = 1'b0;
`endif

        // T6: gap=0, request presented at each acceptance opportunity
        dly1 = 16'd0; wid1 = 16'd2;
        for (int e = 0; e <= 12; e++) begin
            trig1 = (e % 3 == 0) && (e <= 9);
            step();
            if (e >= 1)
                chk_edge("T6", 1, e, e % 3 == 1, e % 3 != 0, e % 3 != 0, e % 3 == 0, 1'b0);
        end
        trig1 = 1'b0;

        // T1: async reset in the 4th active cycle of dly=2 wid=8
        trig0 = 1'b1; dly0 = 16'd2; wid0 = 16'd8;
        step();
        trig0 = 1'b0;
        for (int e = 1; e <= 6; e++) step();
        chk("T1 active before reset", {31'b0, sig0}, 32'd1);
        #3;
        rst = 1'b1;
        #1;
        chk("T1 sig at reset", {31'b0, sig0}, 32'd0);
        chk("T1 busy at reset", {31'b0, busy0}, 32'd0);
        step();
        rst = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            step();
            chk_edge("T1 post", 0, e, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
